// File: rtl/window_gen_3x3_if.sv
// Stream-in / window-out bundle for window_gen_3x3.
// master = the window generator itself, slave = the pixel source / window consumer side.
interface window_gen_3x3_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           in_pixel;
    logic                 in_sof;

    logic [7:0]           pixel_pp, pixel_p0, pixel_pm;
    logic [7:0]           pixel_0p, pixel_00, pixel_0m;
    logic [7:0]           pixel_mp, pixel_m0, pixel_mm;
    logic                 on_edge;
    logic                 out_valid;
    logic [CNT_WIDTH-1:0] out_x;
    logic [CNT_WIDTH-1:0] out_y;
    logic                 frame_done;
    logic                 sof_error;

    modport master (
        input  in_valid, in_pixel, in_sof,
        output in_ready,
        output pixel_pp, pixel_p0, pixel_pm, pixel_0p, pixel_00, pixel_0m,
        output pixel_mp, pixel_m0, pixel_mm,
        output on_edge, out_valid, out_x, out_y, frame_done, sof_error
    );

    modport slave (
        output in_valid, in_pixel, in_sof,
        input  in_ready,
        input  pixel_pp, pixel_p0, pixel_pm, pixel_0p, pixel_00, pixel_0m,
        input  pixel_mp, pixel_m0, pixel_mm,
        input  on_edge, out_valid, out_x, out_y, frame_done, sof_error
    );
endinterface

// File: rtl/window_gen_3x3.sv
// Raster pixel stream -> 3x3 window generator with self-inserted pad column/row.
// Optional WINDOW_GEN_FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module window_gen_3x3 #(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16,
    parameter int CNT_WIDTH  = 16
) (
    input logic              clock,
    input logic              reset,
    window_gen_3x3_if.master bus
`ifdef WINDOW_GEN_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_count
`endif
);
    localparam int AW = $clog2(IMG_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] C_LAST = CNT_WIDTH'(IMG_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] C_PAD  = CNT_WIDTH'(IMG_WIDTH);
    localparam logic [CNT_WIDTH-1:0] R_PAD  = CNT_WIDTH'(IMG_HEIGHT);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_PAD_COL, S_FLUSH, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    c_q, c_d, r_q, r_d;
    logic [1:0][2:0][7:0]    hist_q, hist_d;
    logic [2:0][2:0][7:0]    win_q, win_d;
    logic                    out_valid_q, out_valid_d;
    logic                    on_edge_q, on_edge_d;
    logic [CNT_WIDTH-1:0]    out_x_q, out_x_d, out_y_q, out_y_d;
    logic                    sof_error_q, sof_error_d;

    logic [7:0]              lb1_q [IMG_WIDTH+1];
    logic [7:0]              lb2_q [IMG_WIDTH+1];

    logic                    in_ready, accept, restart, proc, emit;
    logic [CNT_WIDTH-1:0]    pc, pr;
    logic [7:0]              pv;
    logic [AW-1:0]           pa;
    logic [2:0][7:0]         new_col;

    assign in_ready = reset && (state_q == S_IDLE || state_q == S_RUN || state_q == S_DONE);
    assign accept   = bus.in_valid && in_ready;

    // Next-state / beat selection. (pc, pr, pv) is the virtual-grid beat processed this cycle.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        r_d     = r_q;
        restart = 1'b0;
        proc    = 1'b0;
        pc      = c_q;
        pr      = r_q;
        pv      = 8'h00;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                c_d     = '0;
                r_d     = '0;
                restart = accept && bus.in_sof;
            end
            S_RUN: begin
                if (accept && bus.in_sof) begin
                    restart = 1'b1;
                end else if (accept) begin
                    proc = 1'b1;
                    pv   = bus.in_pixel;
                    if (c_q == C_LAST) begin
                        c_d     = C_PAD;
                        state_d = S_PAD_COL;
                    end else begin
                        c_d = c_q + ONE;
                    end
                end
            end
            S_PAD_COL: begin
                proc    = 1'b1;
                c_d     = '0;
                r_d     = r_q + ONE;
                state_d = (r_q + ONE == R_PAD) ? S_FLUSH : S_RUN;
            end
            S_FLUSH: begin
                proc = 1'b1;
                if (c_q == C_PAD) begin
                    c_d     = '0;
                    state_d = S_DONE;
                end else begin
                    c_d = c_q + ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A sof beat always becomes (0,0), whether it opens a frame or abandons one.
        if (restart) begin
            proc    = 1'b1;
            pc      = '0;
            pr      = '0;
            pv      = bus.in_pixel;
            c_d     = ONE;
            r_d     = '0;
            state_d = S_RUN;
        end
    end

    assign pa      = pc[AW-1:0];
    assign new_col = {pv, lb1_q[pa], lb2_q[pa]};
    assign emit    = proc && (pc != '0) && (pr != '0);

    // Window = two previously processed columns plus the column just formed; held while idle.
    always_comb begin
        hist_d      = proc ? {new_col, hist_q[1]} : hist_q;
        win_d       = emit ? {new_col, hist_q[1], hist_q[0]} : win_q;
        out_valid_d = emit;
        out_x_d     = emit ? pc - ONE : out_x_q;
        out_y_d     = emit ? pr - ONE : out_y_q;
        on_edge_d   = emit ? (pc == ONE || pc == C_PAD || pr == ONE || pr == R_PAD) : on_edge_q;
        sof_error_d = restart && (state_q == S_RUN);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            c_q         <= '0;
            r_q         <= '0;
            hist_q      <= '0;
            win_q       <= '0;
            out_valid_q <= 1'b0;
            on_edge_q   <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            sof_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            c_q         <= c_d;
            r_q         <= r_d;
            hist_q      <= hist_d;
            win_q       <= win_d;
            out_valid_q <= out_valid_d;
            on_edge_q   <= on_edge_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            sof_error_q <= sof_error_d;
        end
    end

    // lb1 holds row r-1, lb2 row r-2 at each column; contents are don't-care after reset.
    always_ff @(posedge clock) begin
        if (proc) begin
            lb2_q[pa] <= lb1_q[pa];
            lb1_q[pa] <= pv;
        end
    end

`ifdef WINDOW_GEN_FRAME_CNT_EN
    logic [15:0] frame_count_q, frame_count_d;

    always_comb frame_count_d = (state_q == S_DONE) ? frame_count_q + 16'd1 : frame_count_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) frame_count_q <= '0;
        else        frame_count_q <= frame_count_d;
    end

    assign frame_count = frame_count_q;
`endif

    assign bus.in_ready   = in_ready;
    assign bus.pixel_pp   = win_q[2][2];
    assign bus.pixel_p0   = win_q[2][1];
    assign bus.pixel_pm   = win_q[2][0];
    assign bus.pixel_0p   = win_q[1][2];
    assign bus.pixel_00   = win_q[1][1];
    assign bus.pixel_0m   = win_q[1][0];
    assign bus.pixel_mp   = win_q[0][2];
    assign bus.pixel_m0   = win_q[0][1];
    assign bus.pixel_mm   = win_q[0][0];
    assign bus.on_edge    = on_edge_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_x      = out_x_q;
    assign bus.out_y      = out_y_q;
    assign bus.frame_done = (state_q == S_DONE);
    assign bus.sof_error  = sof_error_q;
endmodule

// File: tb/tb_window_gen_3x3.sv
// Randomized bench for window_gen_3x3: expected windows derived from the image contents.
module tb_window_gen_3x3;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int CW = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    window_gen_3x3_if #(.CNT_WIDTH(CW)) bus ();
`ifdef WINDOW_GEN_FRAME_CNT_EN
    logic [15:0] frame_count;
`endif

    window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_WIDTH(CW)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
`ifdef WINDOW_GEN_FRAME_CNT_EN
        , .frame_count(frame_count)
`endif
    );

    typedef struct packed {
        logic [15:0]          x;
        logic [15:0]          y;
        logic                 edg;
        logic                 last;
        logic [2:0][2:0][7:0] t;   // [dx+1][dy+1]
    } win_t;

    win_t       exp_q[$];
    logic [7:0] img [H][W];
    int checks = 0, errors = 0;
    int cyc = 0, exp_se_cyc = -1, sof_cyc = 0, fd_cyc = 0;
    int win_cnt = 0, edge_cnt = 0, rdy_low = 0, fd_cnt = 0, se_cnt = 0;
    bit mid_frame = 0, stall_prev = 0, pin_seen = 0, pin_edge = 0;
    logic [2:0][2:0][7:0] pin, d;
    win_t e;

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    function automatic logic [71:0] taps();
        return {bus.pixel_pp, bus.pixel_p0, bus.pixel_pm, bus.pixel_0p, bus.pixel_00,
                bus.pixel_0m, bus.pixel_mp, bus.pixel_m0, bus.pixel_mm};
    endfunction

    function automatic logic [7:0] pix(input int x, input int y);
        if (x < 0 || x >= W || y < 0 || y >= H) return 8'h00;
        return img[y][x];
    endfunction

    // Window (x,y) exists once virtual beat (x+1,y+1) has been processed; cut_v < 0 means whole frame.
    task automatic push_frame(input int cut_v);
        win_t w;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                if (cut_v >= 0 && (y + 1) * (W + 1) + (x + 1) >= cut_v) continue;
                w.x    = 16'(x);
                w.y    = 16'(y);
                w.edg  = (x == 0 || x == W - 1 || y == 0 || y == H - 1);
                w.last = (cut_v < 0 && x == W - 1 && y == H - 1);
                for (int dx = -1; dx <= 1; dx++)
                    for (int dy = -1; dy <= 1; dy++)
                        w.t[dx+1][dy+1] = pix(x + dx, y + dy);
                exp_q.push_back(w);
            end
    endtask

    always @(posedge clock) begin
        cyc        <= cyc + 1;
        stall_prev <= reset && bus.in_ready && !bus.in_valid;
    end

    // Compare process: every cycle out of reset.
    always @(negedge clock) begin
        if (reset) begin
            d = taps();
            if (!bus.in_ready) rdy_low++;
            if (stall_prev) chk("no_window_after_stall", bus.out_valid, 0);
            chk("sof_error", bus.sof_error, cyc == exp_se_cyc);
            if (bus.sof_error) se_cnt++;
            if (bus.frame_done) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
            if (bus.out_valid) begin
                win_cnt++;
                if (bus.on_edge) edge_cnt++;
                if (bus.out_x == 1 && bus.out_y == 1) begin
                    pin = d;
                    pin_edge = bus.on_edge;
                    pin_seen = 1;
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_window: got x=%0d y=%0d, none required", bus.out_x, bus.out_y);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_x", bus.out_x, e.x);
                    chk("out_y", bus.out_y, e.y);
                    chk("on_edge", bus.on_edge, e.edg);
                    chk("frame_done_on_window", bus.frame_done, e.last);
                    if (!e.edg) chk("taps", d, e.t);
                end
            end else begin
                chk("frame_done_no_window", bus.frame_done, 0);
            end
        end
    end

    task automatic send_beat(input logic [7:0] p, input bit sof, input int gap);
        int guard;
        guard = 0;
        forever begin
            @(negedge clock);
            if (gap > 0 && $urandom_range(0, 99) < gap) begin
                bus.in_valid = 0;
                bus.in_sof   = 0;
            end else begin
                bus.in_valid = 1;
                bus.in_pixel = p;
                bus.in_sof   = sof;
                if (bus.in_ready) begin
                    if (sof) begin
                        sof_cyc = cyc;
                        if (mid_frame) exp_se_cyc = cyc + 1;
                    end
                    return;
                end
            end
            if (++guard > 200) begin
                checks++;
                errors++;
                $display("FAIL beat_accept_timeout: got no in_ready, required acceptance");
                return;
            end
        end
    endtask

    // mode 0: pixel = 16*row+col, else random. cut_idx stops the frame at that raster pixel.
    task automatic run_frame(input int mode, input int gap, input int cut_idx, input bit do_reset);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = (mode == 0) ? 8'(16 * r + c) : 8'($urandom);
        push_frame(cut_idx < 0 ? -1 : (cut_idx / W) * (W + 1) + cut_idx % W);
        for (int i = 0; i < W * H; i++) begin
            if (i == cut_idx) begin
                if (do_reset) begin
                    @(negedge clock);
                    #2 reset = 0;
                    bus.in_valid = 0;
                    #1;
                    chk("rst_mid_out_valid", bus.out_valid, 0);
                    chk("rst_mid_frame_done", bus.frame_done, 0);
                    chk("rst_mid_in_ready", bus.in_ready, 0);
                    exp_q.delete();
                    mid_frame = 0;
                    repeat (2) @(negedge clock);
                    chk("rst_hold_in_ready", bus.in_ready, 0);
                    chk("rst_hold_out_valid", bus.out_valid, 0);
                    #2 reset = 1;
                end
                return;
            end
            send_beat(img[i / W][i % W], i == 0, gap);
            mid_frame = (i != W * H - 1);
        end
    endtask

    task automatic wait_done(input int fd_target);
        int g;
        g = 0;
        while ((fd_cnt < fd_target || exp_q.size() != 0) && g < 300) begin
            @(negedge clock);
            bus.in_valid = 0;
            bus.in_sof   = 0;
            g++;
        end
        if (g >= 300) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got %0d frame_done, required %0d", fd_cnt, fd_target);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0, se0, w0;
        bus.in_valid = 0;
        bus.in_pixel = 0;
        bus.in_sof   = 0;
        repeat (3) @(negedge clock);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_taps", taps(), 0);
        chk("rst_on_edge", bus.on_edge, 0);
        chk("rst_out_x", bus.out_x, 0);
        chk("rst_out_y", bus.out_y, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_sof_error", bus.sof_error, 0);
`ifdef WINDOW_GEN_FRAME_CNT_EN
        chk("rst_frame_count", frame_count, 0);
`endif
        #2 reset = 1;
        @(negedge clock);
        chk("idle_in_ready", bus.in_ready, 1);

        // Gap-free ramp frame with hand-derived timing and centre (1,1) taps.
        win_cnt = 0; edge_cnt = 0; rdy_low = 0; pin_seen = 0; fd0 = fd_cnt;
        run_frame(0, 0, -1, 0);
        wait_done(fd0 + 1);
        chk("dir_windows", win_cnt, 12);
        chk("dir_edge_windows", edge_cnt, 10);
        chk("dir_inner_windows", win_cnt - edge_cnt, 2);
        chk("dir_done_latency", fd_cyc - sof_cyc, 20);
        chk("dir_ready_low", rdy_low, 8);
        chk("pin_seen", pin_seen, 1);
        chk("pin_on_edge", pin_edge, 0);
        chk("pin_00", pin[1][1], 17);
        chk("pin_mm", pin[0][0], 0);
        chk("pin_pm", pin[2][0], 2);
        chk("pin_mp", pin[0][2], 32);
        chk("pin_pp", pin[2][2], 34);
        chk("pin_p0", pin[2][1], 18);
        chk("pin_0p", pin[1][2], 33);

        // Same ramp with ~50% in_valid gaps, then random images with gaps.
        win_cnt = 0; pin_seen = 0; fd0 = fd_cnt;
        run_frame(0, 50, -1, 0);
        wait_done(fd0 + 1);
        chk("gap_windows", win_cnt, 12);
        chk("gap_pin_00", pin[1][1], 17);
        chk("gap_pin_pp", pin[2][2], 34);
        for (int k = 0; k < 3; k++) begin
            fd0 = fd_cnt;
            run_frame(1, 50, -1, 0);
            wait_done(fd0 + 1);
        end

        // sof at (2,1): abandon, then a full frame starting on that beat.
        se0 = se_cnt; fd0 = fd_cnt; w0 = win_cnt;
        run_frame(0, 0, W + 2, 0);
        run_frame(1, 0, -1, 0);
        wait_done(fd0 + 1);
        chk("abort_sof_error_count", se_cnt - se0, 1);
        chk("abort_frame_done_count", fd_cnt - fd0, 1);
        chk("abort_window_total", win_cnt - w0, 13);

        // Reset at (1,2), then non-sof beats must be discarded.
        w0 = win_cnt;
        run_frame(0, 0, 2 * W + 1, 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            bus.in_valid = 1;
            bus.in_sof   = 0;
            bus.in_pixel = 8'($urandom);
            chk("discard_in_ready", bus.in_ready, 1);
        end
        repeat (3) @(negedge clock) bus.in_valid = 0;
        chk("reset_window_total", win_cnt - w0, 4);

        // Three back-to-back frames.
        fd0 = fd_cnt;
        for (int k = 0; k < 3; k++) run_frame(1, 0, -1, 0);
        wait_done(fd0 + 3);
        chk("b2b_frame_done_count", fd_cnt - fd0, 3);
`ifdef WINDOW_GEN_FRAME_CNT_EN
        chk("frame_count", frame_count, 3);
`endif
        repeat (4) @(negedge clock);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
